// File: rtl/ddr_dq_sequencer.sv
// DQ bank sequencer: drives ODDR data/tristate for DDR2 write bursts with pre/postamble
// and captures IDDR outputs for read bursts after the read latency.
//
// state   | meaning
// IDLE    | ready for a command
// WR_WAIT | counting down write latency before preamble
// WR_PRE  | preamble, bus driven with zeros, first wr_data pulled
// WR_DATA | burst beats on d1/d0
// WR_POST | postamble, bus still driven with zeros
// RD_WAIT | counting down read latency
// RD_CAP  | capturing o1/o0 each cycle
// TURN    | one idle cycle before the bus may be driven again
module ddr_dq_sequencer #(
  parameter int BANK_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int WL         = 3,
  parameter int RL         = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  input  logic                    cmd_write,
  output logic                    cmd_ready,
  output logic                    wr_ready,
  input  logic [2*BANK_WIDTH-1:0] wr_data,
  output logic                    rd_valid,
  output logic [2*BANK_WIDTH-1:0] rd_data,
  output logic                    oe,
  output logic [BANK_WIDTH-1:0]   d1,
  output logic [BANK_WIDTH-1:0]   d0,
  input  logic [BANK_WIDTH-1:0]   o1,
  input  logic [BANK_WIDTH-1:0]   o0
);

  localparam int B    = BURST_LEN / 2;
  localparam int MAXC = ((WL > RL) ? WL : RL) + B + 2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_PRE, WR_DATA, WR_POST, RD_WAIT, RD_CAP, TURN
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] tmr, tmr_nx;
  logic          drive_nx;

  // Timer holds the remaining cycles in the current state; exit on zero.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            if (WL > 1) begin
              state_nx = WR_WAIT;
              tmr_nx   = CW'(WL - 2);
            end else begin
              state_nx = WR_PRE;
              tmr_nx   = '0;
            end
          end else begin
            state_nx = RD_WAIT;
            tmr_nx   = CW'(RL - 1);
          end
        end
      end
      WR_WAIT: begin
        if (tmr == '0) state_nx = WR_PRE;
        else           tmr_nx   = tmr - CW'(1);
      end
      WR_PRE: begin
        state_nx = WR_DATA;
        tmr_nx   = CW'(B - 1);
      end
      WR_DATA: begin
        if (tmr == '0) state_nx = WR_POST;
        else           tmr_nx   = tmr - CW'(1);
      end
      WR_POST: state_nx = IDLE;
      RD_WAIT: begin
        if (tmr == '0) begin
          state_nx = RD_CAP;
          tmr_nx   = CW'(B - 1);
        end else begin
          tmr_nx = tmr - CW'(1);
        end
      end
      RD_CAP: begin
        if (tmr == '0) state_nx = TURN;
        else           tmr_nx   = tmr - CW'(1);
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign drive_nx = (state_nx == WR_PRE) || (state_nx == WR_DATA) || (state_nx == WR_POST);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      oe        <= 1'b1;
      d1        <= '0;
      d0        <= '0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      cmd_ready <= (state_nx == IDLE);
      oe        <= !drive_nx;
      wr_ready  <= (state_nx == WR_PRE) || ((state_nx == WR_DATA) && (tmr_nx != '0));
      if (state_nx == WR_DATA) begin
        d1 <= wr_data[2*BANK_WIDTH-1:BANK_WIDTH];
        d0 <= wr_data[BANK_WIDTH-1:0];
      end else begin
        d1 <= '0;
        d0 <= '0;
      end
      rd_valid <= (state_nx == RD_CAP);
      if (state_nx == RD_CAP) rd_data <= {o1, o0};
    end
  end

endmodule

// File: tb/tb_ddr_dq_sequencer.sv
// Self-checking bench for ddr_dq_sequencer: per-cycle timing checks plus a data scoreboard
// for write beats and read captures.
module tb_ddr_dq_sequencer;

  localparam int W  = 16;
  localparam int BL = 4;
  localparam int WL = 3;
  localparam int RL = 5;
  localparam int B  = BL / 2;

  logic           clk, rst_n, cmd_valid, cmd_write, cmd_ready, wr_ready, rd_valid, oe;
  logic [2*W-1:0] wr_data, rd_data;
  logic [W-1:0]   d1, d0, o1, o0;

  int             n_checks = 0;
  int             n_pass   = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] wr_src[$];
  logic [2*W-1:0] rd_src[$];
  logic [2*W-1:0] last_rd = '0;

  ddr_dq_sequencer #(.BANK_WIDTH(W), .BURST_LEN(BL), .WL(WL), .RL(RL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_ready(cmd_ready), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .oe(oe), .d1(d1), .d0(d0),
    .o1(o1), .o0(o0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic wr, input string tag);
    cmd_valid = 1'b1;
    cmd_write = wr;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s accept: cmd_ready=%b want 1", tag, cmd_ready);
    else n_pass++;
    step();
  endtask

  // Runs write cycles 1..WL+B+2 after an accept; ends in the cycle where cmd_ready returns.
  task automatic write_body(input logic keep_valid, input string tag);
    logic           exp_oe, exp_wrr, exp_rdy;
    logic [2*W-1:0] exp_d;
    cmd_valid = keep_valid;
    for (int k = 1; k <= WL + B + 2; k++) begin
      exp_oe  = !(k >= WL && k <= WL + B + 1);
      exp_wrr = (k >= WL && k <= WL + B - 1);
      exp_rdy = (k == WL + B + 2);
      n_checks++;
      if (oe !== exp_oe) $display("FAIL %s oe c%0d: got %b want %b", tag, k, oe, exp_oe);
      else n_pass++;
      n_checks++;
      if (wr_ready !== exp_wrr) $display("FAIL %s wr_ready c%0d: got %b want %b", tag, k, wr_ready, exp_wrr);
      else n_pass++;
      n_checks++;
      if (cmd_ready !== exp_rdy) $display("FAIL %s cmd_ready c%0d: got %b want %b", tag, k, cmd_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (rd_valid !== 1'b0) $display("FAIL %s rd_valid c%0d: got %b want 0", tag, k, rd_valid);
      else n_pass++;
      exp_d = '0;
      if (k >= WL + 1 && k <= WL + B) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL %s scoreboard c%0d: got empty want beat", tag, k);
        end else begin
          exp_d = sb.pop_front();
        end
      end
      n_checks++;
      if ({d1, d0} !== exp_d) $display("FAIL %s d c%0d: got %h want %h", tag, k, {d1, d0}, exp_d);
      else n_pass++;
      if (exp_wrr) begin
        wr_data = (wr_src.size() > 0) ? wr_src.pop_front() : 32'h0BAD_0BAD;
        sb.push_back(wr_data);
      end else begin
        wr_data = $urandom;
      end
      if (k < WL + B + 2) step();
    end
  endtask

  // Runs read cycles 1..RL+B+2 after an accept; next_write is what cmd_write shows while busy.
  task automatic read_body(input logic keep_valid, input logic next_write, input string tag);
    logic           exp_val, exp_rdy;
    logic [2*W-1:0] exp_rd;
    cmd_valid = keep_valid;
    cmd_write = next_write;
    for (int k = 1; k <= RL + B + 2; k++) begin
      exp_val = (k >= RL + 1 && k <= RL + B);
      exp_rdy = (k == RL + B + 2);
      n_checks++;
      if (oe !== 1'b1) $display("FAIL %s oe c%0d: got %b want 1", tag, k, oe);
      else n_pass++;
      n_checks++;
      if (wr_ready !== 1'b0 || {d1, d0} !== '0)
        $display("FAIL %s wr_idle c%0d: got wr_ready=%b d=%h want 0/0", tag, k, wr_ready, {d1, d0});
      else n_pass++;
      n_checks++;
      if (cmd_ready !== exp_rdy) $display("FAIL %s cmd_ready c%0d: got %b want %b", tag, k, cmd_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (rd_valid !== exp_val) $display("FAIL %s rd_valid c%0d: got %b want %b", tag, k, rd_valid, exp_val);
      else n_pass++;
      exp_rd = last_rd;
      if (exp_val) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL %s scoreboard c%0d: got empty want beat", tag, k);
        end else begin
          exp_rd = sb.pop_front();
        end
      end
      last_rd = exp_rd;
      n_checks++;
      if (rd_data !== exp_rd) $display("FAIL %s rd_data c%0d: got %h want %h", tag, k, rd_data, exp_rd);
      else n_pass++;
      if (k >= RL && k <= RL + B - 1) begin
        {o1, o0} = (rd_src.size() > 0) ? rd_src.pop_front() : 32'h0BAD_0BAD;
        sb.push_back({o1, o0});
      end else begin
        {o1, o0} = $urandom;
      end
      if (k < RL + B + 2) step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    wr_data = '0; o1 = '0; o0 = '0;
    #23;
    n_checks++;
    if (cmd_ready !== 1'b1 || oe !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 ||
        {d1, d0} !== '0 || rd_data !== '0)
      $display("FAIL reset: got rdy=%b oe=%b wrr=%b rv=%b d=%h rd=%h want 1 1 0 0 0 0",
               cmd_ready, oe, wr_ready, rd_valid, {d1, d0}, rd_data);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1 || oe !== 1'b1) $display("FAIL post_reset: got rdy=%b oe=%b want 1 1", cmd_ready, oe);
    else n_pass++;
  endtask

  task automatic test_write_basic();
    wr_src = {32'h1111_2222, 32'h3333_4444};
    do_accept(1'b1, "wr_basic");
    write_body(1'b0, "wr_basic");
    step();
  endtask

  task automatic test_read_basic();
    rd_src = {32'hAAAA_5555, 32'hBEEF_CAFE};
    do_accept(1'b0, "rd_basic");
    read_body(1'b0, 1'b0, "rd_basic");
    step();
  endtask

  task automatic test_back_to_back();
    rd_src = {32'h0123_4567, 32'h89AB_CDEF};
    wr_src = {32'hCAFE_F00D, 32'h1234_5678};
    do_accept(1'b0, "b2b_rd");
    read_body(1'b1, 1'b1, "b2b_rd");
    do_accept(1'b1, "b2b_wr");
    write_body(1'b0, "b2b_wr");
    step();
  endtask

  task automatic test_busy_valid();
    for (int i = 0; i < 2; i++) begin
      wr_src = {$urandom, $urandom};
      do_accept(1'b1, "busy_wr");
      write_body(1'b1, "busy_wr");
    end
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 3; i++) begin
      wr_src = {$urandom, $urandom};
      do_accept(1'b1, "mix_wr");
      write_body(1'b0, "mix_wr");
      rd_src = {$urandom, $urandom};
      do_accept(1'b0, "mix_rd");
      read_body(1'b0, 1'b0, "mix_rd");
    end
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_write();
    do_accept(1'b1, "rst_mid");
    cmd_valid = 1'b0;
    step();
    step();
    wr_data = 32'hDEAD_BEEF;
    step();
    n_checks++;
    if ({d1, d0} !== 32'hDEAD_BEEF || oe !== 1'b0)
      $display("FAIL rst_mid pre: got d=%h oe=%b want deadbeef 0", {d1, d0}, oe);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (oe !== 1'b1 || {d1, d0} !== '0 || wr_ready !== 1'b0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL rst_mid async: got oe=%b d=%h wrr=%b rdy=%b rv=%b want 1 0 0 1 0",
               oe, {d1, d0}, wr_ready, cmd_ready, rd_valid);
    else n_pass++;
    #3;
    rst_n = 1'b1;
    sb.delete();
    last_rd = '0;
    for (int k = 0; k < 8; k++) begin
      wr_data = $urandom;
      step();
      n_checks++;
      if (oe !== 1'b1 || {d1, d0} !== '0 || wr_ready !== 1'b0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0)
        $display("FAIL rst_mid after c%0d: got oe=%b d=%h wrr=%b rdy=%b rv=%b want 1 0 0 1 0",
                 k, oe, {d1, d0}, wr_ready, cmd_ready, rd_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_back_to_back();
    test_busy_valid();
    test_random_mix();
    test_reset_mid_write();
    test_read_basic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
